lfsr_scrambler: RTL
===================

LFSR_SCRAMBLER -- requirements
Module: lfsr_scrambler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per beat (1..256).
REQ-002 SHALL have parameter LFSR_LEN, default 7, meaning shift-register length L (2..32).
REQ-003 SHALL have parameter POLY, default 7'b1001000, meaning L-bit tap mask; POLY[k]=1 selects term x^(k+1), and x^0 is implicit.
REQ-004 SHALL have parameter SEED, default all-ones, meaning the L-bit power-up and reset state.
REQ-005 SHALL have parameter MODE, default 0, meaning 0=additive, 1=multiplicative scramble, 2=multiplicative descramble.
REQ-006 SHALL have parameter RESEED_ON_LAST, default 0, meaning 1 reloads state after each tlast beat.
REQ-007 SHALL have port aclk, input, 1 bit, the clock.
REQ-008 SHALL have port aresetn, input, 1 bit, reset; synchronous, active-low.
REQ-009 SHALL have port s_axis_tdata, input, WIDTH bits; s_axis_tvalid, input, 1 bit; s_axis_tready, output, 1 bit; s_axis_tlast, input, 1 bit.
REQ-010 SHALL have port m_axis_tdata, output, WIDTH bits; m_axis_tvalid, output, 1 bit; m_axis_tready, input, 1 bit; m_axis_tlast, output, 1 bit.
REQ-011 SHALL have port cfg_seed, input, L bits, runtime seed; and cfg_load, input, 1 bit, a one-cycle pulse that loads cfg_seed.

Function
REQ-012 SHALL treat data bit 0 as first in time; bit i is processed after bits 0..i-1 of the same beat.
REQ-013 SHALL define state s[L-1:0], with s[k] being the register bit shifted in k+1 steps earlier; per bit, fb = XOR of s[k] over all k where POLY[k]=1, and out = in XOR fb.
REQ-014 SHALL, per bit, shift s <= {s[L-2:0], x}, where x=fb (MODE 0), x=out (MODE 1) or x=in (MODE 2).
REQ-015 SHALL compute all WIDTH bit-steps combinationally within one beat and update state only on an input handshake (s_axis_tvalid & s_axis_tready).
REQ-016 SHALL register out and tlast into a single output stage, giving 1-cycle latency and full throughput.
REQ-017 SHALL drive s_axis_tready = ~m_axis_tvalid | m_axis_tready, with no combinational path from s_axis_tvalid to any output.
REQ-018 SHALL set m_axis_tvalid on an input handshake, clear it on an output handshake with no input handshake, and hold it otherwise; m_axis_tdata and m_axis_tlast SHALL stay stable while stalled.
REQ-019 SHALL keep a seed register, initialised to SEED; cfg_load writes cfg_seed into both the seed register and the state.
REQ-020 SHALL, when cfg_load coincides with an input handshake, process that beat with the old state, and the next state SHALL be cfg_seed.
REQ-021 SHALL, with RESEED_ON_LAST=1, set state to the seed register after the handshake of a tlast beat; a coincident cfg_load SHALL take priority (state = cfg_seed).
REQ-022 SHALL pass all-zero state unchanged (lock-up is legal and not detected); a cfg_seed of 0 is accepted.

Reset
REQ-023 SHALL, while aresetn=0 at a rising edge, set m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, state=SEED and seed register=SEED.
REQ-024 SHALL discard the buffered output beat on reset mid-stall, and the first post-reset beat SHALL use SEED.
REQ-025 SHALL hold s_axis_tready=1 during and after reset while the output stage is empty.

Structure
REQ-026 SHALL use package scrambler_pkg to hold the MODE constants (MODE_ADD, MODE_MSCR, MODE_MDSC) and POLY_80211=7'b1001000.
REQ-027 SHALL place the WIDTH-step combinational next-state/output computation in sub-module lfsr_step, parameterised by WIDTH, LFSR_LEN, POLY and MODE.

Verification
REQ-028 SHALL cover: WIDTH=8, MODE 0, default POLY/SEED, zero input, first beat -> m_axis_tdata=8'h70, matching a bit-serial reference model for 64 beats.
REQ-029 SHALL cover: MODE 1 instance chained into a MODE 2 instance with random data, 1000 beats -> output equals input from the first beat.
REQ-030 SHALL cover: MODE 2 descrambler started with the wrong seed -> output correct from beat ceil(L/WIDTH)+1 onward.
REQ-031 SHALL cover: m_axis_tready random 30% duty, random s_axis_tvalid -> no beat lost or duplicated, outputs stable while stalled, throughput 1 beat/clk when m_axis_tready=1.
REQ-032 SHALL cover: RESEED_ON_LAST=1, two 4-beat packets of zeros -> both packets produce identical data; cfg_load coinciding with a tlast beat -> next packet uses cfg_seed.
REQ-033 SHALL cover: aresetn asserted while m_axis_tvalid=1 and m_axis_tready=0 -> m_axis_tvalid=0 next cycle, and the next beat matches the first-beat value of REQ-028.

Source files
------------

// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared mode encodings and the 802.11 polynomial for the LFSR scrambler
package scrambler_pkg;
  localparam int MODE_ADD = 0;
  localparam int MODE_MSCR = 1;
  localparam int MODE_MDSC = 2;
  localparam logic [6:0] POLY_80211 = 7'b1001000;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: unrolls WIDTH serial LFSR bit-steps into one combinational beat, bit 0 first
module lfsr_step
  import scrambler_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] POLY = LFSR_LEN'(POLY_80211),
  parameter int MODE = MODE_ADD
) (
  input  logic [LFSR_LEN-1:0] state,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic [LFSR_LEN-1:0] next_state
);
  logic [LFSR_LEN-1:0] s;
  logic fb;
  always_comb begin
    s = state;
    fb = 1'b0;
    dout = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fb = ^(s & POLY);
      dout[i] = din[i] ^ fb;
      s = {s[LFSR_LEN-2:0], MODE == MODE_ADD ? fb : MODE == MODE_MSCR ? dout[i] : din[i]};
    end
    next_state = s;
  end
endmodule

// File: rtl/lfsr_scrambler.sv
// lfsr_scrambler: AXI-Stream LFSR scrambler/descrambler with one registered output stage
module lfsr_scrambler
  import scrambler_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] POLY = LFSR_LEN'(POLY_80211),
  parameter logic [LFSR_LEN-1:0] SEED = '1,
  parameter int MODE = MODE_ADD,
  parameter int RESEED_ON_LAST = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [WIDTH-1:0]    s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [WIDTH-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic [LFSR_LEN-1:0] cfg_seed,
  input  logic                cfg_load
);
  logic [LFSR_LEN-1:0] state, seed_reg, next_state;
  logic [WIDTH-1:0] step_out;
  logic in_hs;
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign in_hs = s_axis_tvalid & s_axis_tready;
  lfsr_step #(
    .WIDTH(WIDTH), .LFSR_LEN(LFSR_LEN), .POLY(POLY), .MODE(MODE)
  ) u_step (
    .state(state), .din(s_axis_tdata), .dout(step_out), .next_state(next_state)
  );
  // cfg_load wins over tlast reseed; a coincident beat still used the old state
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      state <= SEED;
      seed_reg <= SEED;
    end else begin
      if (cfg_load) seed_reg <= cfg_seed;
      state <= cfg_load ? cfg_seed
             : (in_hs && s_axis_tlast && RESEED_ON_LAST != 0) ? seed_reg
             : in_hs ? next_state : state;
      if (in_hs) begin
        m_axis_tdata <= step_out;
        m_axis_tlast <= s_axis_tlast;
      end
      m_axis_tvalid <= in_hs | (m_axis_tvalid & ~m_axis_tready);
    end
  end
endmodule
